// File: rtl/time_counter_gen.sv
// Clock/timer generator: prescaled sub-second tick feeding a seconds/minutes/hours
// chain that counts up (clock) or down (timer), with a manual set mode.
module time_counter_gen #(
    parameter int unsigned CLK_HZ   = 10000,
    parameter int unsigned TICK_HZ  = 100,
    parameter int unsigned HOUR_MOD = 24,
    parameter int unsigned OUT_W    = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             setting_enable,
    input  logic [1:0]       set_field,
    input  logic             inc_short,
    input  logic             dec_short,
    input  logic             count_down,
    output logic [OUT_W-1:0] small_sec_out,
    output logic [OUT_W-1:0] seconds_out,
    output logic [OUT_W-1:0] minutes_out,
    output logic [OUT_W-1:0] hours_out,
    output logic             day_wrap,
    output logic             done,
    output logic [1:0]       state_out
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    LAST_PRE = PW'(DIV - 1);
    localparam logic [OUT_W-1:0] LAST_SS  = OUT_W'(TICK_HZ - 1);
    localparam logic [OUT_W-1:0] LAST_SM  = OUT_W'(59);
    localparam logic [OUT_W-1:0] LAST_HR  = OUT_W'(HOUR_MOD - 1);
    localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SET     = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic            inc_q, dec_q;
    logic            inc_edge, dec_edge;
    logic [OUT_W-1:0] up_ss, up_s, up_m, up_h;
    logic            up_wrap;
    logic [OUT_W-1:0] dn_ss, dn_s, dn_m, dn_h;
    logic            now_zero, dn_zero;
    logic [OUT_W-1:0] set_s, set_m, set_h;
    logic            step_up, step_dn;

    assign state_out = state;
    assign inc_edge  = inc_short & ~inc_q;
    assign dec_edge  = dec_short & ~dec_q;
    assign step_up   = inc_edge & ~dec_edge;
    assign step_dn   = dec_edge & ~inc_edge;

    // Count-up successor with carry through the whole chain
    always_comb begin
        up_ss   = small_sec_out + ONE;
        up_s    = seconds_out;
        up_m    = minutes_out;
        up_h    = hours_out;
        up_wrap = 1'b0;
        if (small_sec_out == LAST_SS) begin
            up_ss = '0;
            if (seconds_out == LAST_SM) begin
                up_s = '0;
                if (minutes_out == LAST_SM) begin
                    up_m = '0;
                    if (hours_out == LAST_HR) begin
                        up_h    = '0;
                        up_wrap = 1'b1;
                    end else begin
                        up_h = hours_out + ONE;
                    end
                end else begin
                    up_m = minutes_out + ONE;
                end
            end else begin
                up_s = seconds_out + ONE;
            end
        end
    end

    // Count-down successor with borrow; dn_zero flags arrival at (or sitting on) zero
    always_comb begin
        dn_ss    = small_sec_out - ONE;
        dn_s     = seconds_out;
        dn_m     = minutes_out;
        dn_h     = hours_out;
        now_zero = (small_sec_out == '0) && (seconds_out == '0) &&
                   (minutes_out == '0) && (hours_out == '0);
        if (small_sec_out == '0) begin
            dn_ss = LAST_SS;
            if (seconds_out == '0) begin
                dn_s = LAST_SM;
                if (minutes_out == '0) begin
                    dn_m = LAST_SM;
                    dn_h = (hours_out == '0) ? LAST_HR : hours_out - ONE;
                end else begin
                    dn_m = minutes_out - ONE;
                end
            end else begin
                dn_s = seconds_out - ONE;
            end
        end
        dn_zero = now_zero || ((dn_ss == '0) && (dn_s == '0) &&
                               (dn_m == '0) && (dn_h == '0));
    end

    // Manual set: wrap the selected field only, no carry/borrow
    always_comb begin
        set_s = seconds_out;
        set_m = minutes_out;
        set_h = hours_out;
        if (step_up) begin
            case (set_field)
                2'd0:    set_s = (seconds_out == LAST_SM) ? '0 : seconds_out + ONE;
                2'd1:    set_m = (minutes_out == LAST_SM) ? '0 : minutes_out + ONE;
                2'd2:    set_h = (hours_out == LAST_HR) ? '0 : hours_out + ONE;
                default: ;
            endcase
        end else if (step_dn) begin
            case (set_field)
                2'd0:    set_s = (seconds_out == '0) ? LAST_SM : seconds_out - ONE;
                2'd1:    set_m = (minutes_out == '0) ? LAST_SM : minutes_out - ONE;
                2'd2:    set_h = (hours_out == '0) ? LAST_HR : hours_out - ONE;
                default: ;
            endcase
        end
    end

    // FSM, prescaler, time registers and pulse outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_STOP;
            presc         <= '0;
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
            small_sec_out <= '0;
            seconds_out   <= '0;
            minutes_out   <= '0;
            hours_out     <= '0;
            day_wrap      <= 1'b0;
            done          <= 1'b0;
        end else begin
            day_wrap <= 1'b0;
            done     <= 1'b0;
            inc_q    <= inc_short;
            dec_q    <= dec_short;
            if (setting_enable) begin
                state <= ST_SET;
                if (state != ST_SET) begin
                    presc         <= '0;
                    small_sec_out <= '0;
                end else begin
                    seconds_out <= set_s;
                    minutes_out <= set_m;
                    hours_out   <= set_h;
                end
            end else begin
                case (state)
                    ST_SET:  state <= enable ? ST_RUN : ST_STOP;
                    ST_STOP: if (enable) state <= ST_RUN;
                    ST_RUN: begin
                        if (!enable) begin
                            state <= ST_STOP;
                        end else if (presc == LAST_PRE) begin
                            presc <= '0;
                            if (count_down) begin
                                if (dn_zero) begin
                                    small_sec_out <= '0;
                                    seconds_out   <= '0;
                                    minutes_out   <= '0;
                                    hours_out     <= '0;
                                    state         <= ST_EXPIRED;
                                    done          <= 1'b1;
                                end else begin
                                    small_sec_out <= dn_ss;
                                    seconds_out   <= dn_s;
                                    minutes_out   <= dn_m;
                                    hours_out     <= dn_h;
                                end
                            end else begin
                                small_sec_out <= up_ss;
                                seconds_out   <= up_s;
                                minutes_out   <= up_m;
                                hours_out     <= up_h;
                                day_wrap      <= up_wrap;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    ST_EXPIRED: if (!enable || !count_down) state <= ST_STOP;
                    default: state <= ST_STOP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_time_counter_gen.sv
// Bench for time_counter_gen: directed scenarios plus randomized cycles against
// a model that keeps the time as a single count of sub-second ticks.
module tb_time_counter_gen;

    localparam int CLK_HZ = 100;
    localparam int T      = 10;
    localparam int HMOD   = 24;
    localparam int W      = 14;
    localparam int DIV    = CLK_HZ / T;
    localparam int TOT    = HMOD * 3600 * T;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         setting_enable;
    logic [1:0]   set_field;
    logic         inc_short;
    logic         dec_short;
    logic         count_down;
    logic [W-1:0] small_sec_out, seconds_out, minutes_out, hours_out;
    logic         day_wrap, done;
    logic [1:0]   state_out;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_t, m_mode, m_phase;
    bit m_incp, m_decp, m_wrap, m_done;

    time_counter_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(T), .HOUR_MOD(HMOD), .OUT_W(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .setting_enable(setting_enable),
        .set_field(set_field), .inc_short(inc_short), .dec_short(dec_short),
        .count_down(count_down), .small_sec_out(small_sec_out), .seconds_out(seconds_out),
        .minutes_out(minutes_out), .hours_out(hours_out), .day_wrap(day_wrap),
        .done(done), .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset;
        m_t = 0; m_mode = 0; m_phase = 0;
        m_incp = 0; m_decp = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic model_step;
        bit ie, de;
        int ss, s, m, h, d;
        ie = inc_short && !m_incp;
        de = dec_short && !m_decp;
        m_incp = inc_short;
        m_decp = dec_short;
        m_wrap = 0;
        m_done = 0;
        if (setting_enable) begin
            if (m_mode != 2) begin
                m_phase = 0;
                m_t = m_t - (m_t % T);
            end else if (set_field != 2'd3 && ie != de) begin
                d  = ie ? 1 : -1;
                ss = m_t % T;
                s  = (m_t / T) % 60;
                m  = (m_t / (T * 60)) % 60;
                h  = m_t / (T * 3600);
                case (set_field)
                    2'd0: s = (s + d + 60) % 60;
                    2'd1: m = (m + d + 60) % 60;
                    default: h = (h + d + HMOD) % HMOD;
                endcase
                m_t = ((h * 60 + m) * 60 + s) * T + ss;
            end
            m_mode = 2;
        end else begin
            case (m_mode)
                2: m_mode = enable ? 1 : 0;
                0: if (enable) m_mode = 1;
                1: begin
                    if (!enable) m_mode = 0;
                    else if (m_phase == DIV - 1) begin
                        m_phase = 0;
                        if (count_down) begin
                            if (m_t <= 1) begin
                                m_t = 0; m_mode = 3; m_done = 1;
                            end else m_t = m_t - 1;
                        end else begin
                            m_t = (m_t + 1) % TOT;
                            if (m_t == 0) m_wrap = 1;
                        end
                    end else m_phase = m_phase + 1;
                end
                default: if (!enable || !count_down) m_mode = 0;
            endcase
        end
    endtask

    function automatic logic [59:0] model_vec();
        return {W'(m_t % T), W'((m_t / T) % 60), W'((m_t / (T * 60)) % 60),
                W'(m_t / (T * 3600)), m_wrap, m_done, 2'(m_mode)};
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, sample after the edge
    task automatic cycle(input bit en, input bit se, input logic [1:0] sf,
                         input bit inc, input bit dec, input bit cd);
        enable = en; setting_enable = se; set_field = sf;
        inc_short = inc; dec_short = dec; count_down = cd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input bit se);
        enable = 0; setting_enable = se; set_field = 2'd3;
        inc_short = 0; dec_short = 0; count_down = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        #2 reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1'b0);
        n_checks++;
        if ({small_sec_out, seconds_out, minutes_out, hours_out, day_wrap, done, state_out} !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_state: got ss=%0d s=%0d m=%0d h=%0d wrap=%b done=%b st=%0d, want all 0",
                     small_sec_out, seconds_out, minutes_out, hours_out, day_wrap, done, state_out);
        end
    endtask

    task automatic test_set;
        do_reset(1'b1);
        cycle(0, 1, 2'd2, 0, 0, 0);
        n_checks++;
        if (state_out !== 2'd2) begin
            n_fail++; $display("FAIL set_enter: state=%0d want 2", state_out);
        end
        repeat (3) begin
            cycle(0, 1, 2'd2, 1, 0, 0);
            cycle(0, 1, 2'd2, 0, 0, 0);
        end
        n_checks++;
        if (hours_out !== W'(3)) begin
            n_fail++; $display("FAIL set_hours_inc: hours=%0d want 3", hours_out);
        end
        cycle(0, 1, 2'd1, 0, 1, 0);
        cycle(0, 1, 2'd1, 0, 0, 0);
        n_checks++;
        if (minutes_out !== W'(59) || hours_out !== W'(3)) begin
            n_fail++; $display("FAIL set_min_dec: min=%0d hours=%0d want 59,3", minutes_out, hours_out);
        end
    endtask

    task automatic test_tick_timing;
        do_reset(1'b0);
        cycle(1, 0, 2'd3, 0, 0, 0);
        n_checks++;
        if (state_out !== 2'd1 || small_sec_out !== W'(0)) begin
            n_fail++; $display("FAIL run_enter: state=%0d ss=%0d want 1,0", state_out, small_sec_out);
        end
        for (int i = 1; i <= 100; i++) begin
            cycle(1, 0, 2'd3, 0, 0, 0);
            if (i == 9) begin
                n_checks++;
                if (small_sec_out !== W'(0)) begin
                    n_fail++; $display("FAIL tick_early: ss=%0d at cycle 9 want 0", small_sec_out);
                end
            end
            if (i == 10) begin
                n_checks++;
                if (small_sec_out !== W'(1)) begin
                    n_fail++; $display("FAIL first_tick: ss=%0d at cycle 10 want 1", small_sec_out);
                end
            end
            if (i == 100) begin
                n_checks++;
                if (seconds_out !== W'(1) || small_sec_out !== W'(0)) begin
                    n_fail++; $display("FAIL first_second: s=%0d ss=%0d want 1,0", seconds_out, small_sec_out);
                end
            end
        end
    endtask

    task automatic test_day_wrap;
        int pulses;
        do_reset(1'b0);
        cycle(0, 1, 2'd2, 0, 0, 0);
        for (int f = 2; f >= 0; f--) begin
            cycle(0, 1, 2'(f), 0, 1, 0);
            cycle(0, 1, 2'(f), 0, 0, 0);
        end
        n_checks++;
        if (hours_out !== W'(23) || minutes_out !== W'(59) || seconds_out !== W'(59)) begin
            n_fail++; $display("FAIL set_wrap_dec: %0d:%0d:%0d want 23:59:59", hours_out, minutes_out, seconds_out);
        end
        cycle(1, 0, 2'd3, 0, 0, 0);
        pulses = 0;
        for (int i = 1; i <= 105; i++) begin
            cycle(1, 0, 2'd3, 0, 0, 0);
            if (day_wrap) pulses++;
            if (i == 99) begin
                n_checks++;
                if (small_sec_out !== W'(9) || hours_out !== W'(23) || day_wrap !== 1'b0) begin
                    n_fail++; $display("FAIL pre_wrap: ss=%0d h=%0d wrap=%b want 9,23,0", small_sec_out, hours_out, day_wrap);
                end
            end
            if (i == 100) begin
                n_checks++;
                if ({small_sec_out, seconds_out, minutes_out, hours_out} !== 56'd0 || day_wrap !== 1'b1) begin
                    n_fail++; $display("FAIL day_wrap: %0d:%0d:%0d.%0d wrap=%b want 0:0:0.0 wrap=1",
                                       hours_out, minutes_out, seconds_out, small_sec_out, day_wrap);
                end
            end
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL wrap_pulse_count: %0d want 1", pulses);
        end
    endtask

    task automatic test_countdown;
        int pulses;
        do_reset(1'b0);
        cycle(0, 1, 2'd0, 0, 0, 1);
        cycle(0, 1, 2'd0, 1, 0, 1);
        cycle(0, 1, 2'd0, 0, 0, 1);
        cycle(1, 0, 2'd3, 0, 0, 1);
        pulses = 0;
        for (int i = 1; i <= 110; i++) begin
            cycle(1, 0, 2'd3, 0, 0, 1);
            if (done) pulses++;
            if (i == 10) begin
                n_checks++;
                if (small_sec_out !== W'(9) || seconds_out !== W'(0)) begin
                    n_fail++; $display("FAIL cd_borrow: s=%0d ss=%0d want 0,9", seconds_out, small_sec_out);
                end
            end
            if (i == 100) begin
                n_checks++;
                if ({small_sec_out, seconds_out, minutes_out, hours_out} !== 56'd0 ||
                    done !== 1'b1 || state_out !== 2'd3) begin
                    n_fail++; $display("FAIL cd_expire: ss=%0d s=%0d done=%b st=%0d want 0,0,1,3",
                                       small_sec_out, seconds_out, done, state_out);
                end
            end
        end
        n_checks++;
        if (pulses !== 1 || state_out !== 2'd3 || {small_sec_out, seconds_out} !== 28'd0) begin
            n_fail++; $display("FAIL cd_hold: done_pulses=%0d st=%0d ss=%0d s=%0d want 1,3,0,0",
                               pulses, state_out, small_sec_out, seconds_out);
        end
    endtask

    task automatic test_conflict;
        do_reset(1'b0);
        cycle(0, 1, 2'd0, 0, 0, 0);
        cycle(0, 1, 2'd0, 1, 0, 0);
        cycle(0, 1, 2'd0, 0, 0, 0);
        cycle(0, 1, 2'd0, 1, 1, 0);
        cycle(0, 1, 2'd0, 0, 0, 0);
        n_checks++;
        if (seconds_out !== W'(1)) begin
            n_fail++; $display("FAIL inc_dec_same: s=%0d want 1", seconds_out);
        end
        cycle(0, 1, 2'd3, 1, 0, 0);
        cycle(0, 1, 2'd3, 0, 0, 0);
        n_checks++;
        if ({seconds_out, minutes_out, hours_out} !== {W'(1), W'(0), W'(0)}) begin
            n_fail++; $display("FAIL field_none: %0d:%0d:%0d want 0:0:1", hours_out, minutes_out, seconds_out);
        end
        cycle(0, 0, 2'd0, 0, 0, 0);
        repeat (3) begin
            cycle(0, 0, 2'd0, 1, 0, 0);
            cycle(0, 0, 2'd0, 0, 0, 0);
        end
        n_checks++;
        if (seconds_out !== W'(1) || state_out !== 2'd0) begin
            n_fail++; $display("FAIL inc_outside_set: s=%0d st=%0d want 1,0", seconds_out, state_out);
        end
    endtask

    task automatic test_async_reset;
        do_reset(1'b0);
        repeat (36) cycle(1, 0, 2'd3, 0, 0, 0);
        n_checks++;
        if (small_sec_out !== W'(3) || state_out !== 2'd1) begin
            n_fail++; $display("FAIL pre_async: ss=%0d st=%0d want 3,1", small_sec_out, state_out);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({small_sec_out, seconds_out, minutes_out, hours_out, day_wrap, done, state_out} !== 60'd0) begin
            n_fail++; $display("FAIL async_reset: ss=%0d st=%0d want all 0 before clock", small_sec_out, state_out);
        end
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_random;
        bit cd;
        logic [59:0] act;
        cd = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) cd = ~cd;
            cycle($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 3,
                  2'($urandom_range(0, 3)), $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 30, cd);
            act = {small_sec_out, seconds_out, minutes_out, hours_out, day_wrap, done, state_out};
            n_checks++;
            if (act !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle %0d: got %h want %h", i, act, model_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        enable = 0; setting_enable = 0; set_field = 2'd3;
        inc_short = 0; dec_short = 0; count_down = 0;
        model_reset();
        test_reset();
        test_set();
        test_tick_timing();
        test_day_wrap();
        test_countdown();
        test_conflict();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_counter_gen.md
TIME_COUNTER_GEN -- requirements
Module: time_counter_gen

Interface
REQ-001 Parameter CLK_HZ, default 10000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, small_sec tick rate; DIV = CLK_HZ/TICK_HZ, integer, >= 2.
REQ-003 Parameter HOUR_MOD, default 24, hours range 0..HOUR_MOD-1 (legal values 12 or 24).
REQ-004 Parameter OUT_W, default 14, width of every time output.
REQ-005 Port clk  in  1  single clock for all logic.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port enable  in  1  run request; 1 = time advances.
REQ-008 Port setting_enable  in  1  1 = manual set mode; overrides enable.
REQ-009 Port set_field  in  2  field selected in set mode: 0 = seconds, 1 = minutes, 2 = hours, 3 = none.
REQ-010 Port inc_short  in  1  level input; each rising edge adds 1 in set mode.
REQ-011 Port dec_short  in  1  level input; each rising edge subtracts 1 in set mode.
REQ-012 Port count_down  in  1  0 = count up, 1 = count down (timer).
REQ-013 Port small_sec_out  out  OUT_W  sub-second count, 0..TICK_HZ-1.
REQ-014 Port seconds_out / minutes_out  out  OUT_W each  0..59.
REQ-015 Port hours_out  out  OUT_W  0..HOUR_MOD-1.
REQ-016 Port day_wrap  out  1  one-cycle pulse on count-up wrap to all-zero.
REQ-017 Port done  out  1  one-cycle pulse when count-down reaches all-zero.
REQ-018 Port state_out  out  2  current FSM state code.

Function
REQ-019 FSM states: STOP=0, RUN=1, SET=2, EXPIRED=3; all outputs registered.
REQ-020 Priority: reset > setting_enable > enable.
REQ-021 Any state with setting_enable=1 -> SET on the next edge; entering SET clears the prescaler and small_sec_out to 0.
REQ-022 SET with setting_enable=0 -> RUN if enable=1, else STOP.
REQ-023 STOP with enable=1 -> RUN; RUN with enable=0 -> STOP; prescaler and time hold in STOP.
REQ-024 In RUN the prescaler counts 0..DIV-1; a tick fires on the edge where the prescaler equals DIV-1, and the prescaler wraps to 0; the first tick fires DIV cycles after entering RUN.
REQ-025 Count-up tick: small_sec +1 and carries at TICK_HZ-1, then through seconds 59 -> minutes 59 -> hours HOUR_MOD-1; the full wrap sets all fields to 0 and pulses day_wrap on the same edge.
REQ-026 Count-down tick: small_sec -1 and borrows through the chain; when the result is all-zero, the FSM enters EXPIRED, pulses done once, and holds all fields at 0.
REQ-027 A count-down tick taken while all fields are already 0 (e.g. run started from zero) does not underflow; the block enters EXPIRED and pulses done.
REQ-028 EXPIRED -> STOP when enable=0 or count_down=0; EXPIRED -> SET per REQ-021.
REQ-029 A change of count_down in RUN takes effect at the next tick; the prescaler is not cleared.
REQ-030 Edge detection uses one registered copy of each input; one increment per rising edge, regardless of pulse length.
REQ-031 In SET, an inc edge adds 1 to the selected field, wrapping within its range (59->0, HOUR_MOD-1->0) with no carry into the next field.
REQ-032 In SET, a dec edge subtracts 1 with wrap (0->59, 0->HOUR_MOD-1) and no borrow.
REQ-033 Inc and dec edges in the same cycle leave the fields unchanged; set_field=3 ignores both edges.
REQ-034 Edges occurring outside SET are discarded; an edge coincident with the edge that enters SET is discarded.
REQ-035 day_wrap and done never assert in STOP or SET.

Reset
REQ-036 Asynchronous reset drives state STOP, prescaler 0, all time outputs 0, day_wrap 0, done 0, and the edge-detect registers 0.
REQ-037 An input held high through reset release counts as a rising edge on the first clock after release.
REQ-038 Reset asserted mid-RUN or mid-SET takes effect immediately, without waiting for a clock edge.

Verification
REQ-039 Defaults, reset released with setting_enable=1, set_field=2, inc_short pulsed 3 times -> hours_out=3; set_field=1, dec_short pulsed once -> minutes_out=59, hours_out stays 3.
REQ-040 CLK_HZ=100, TICK_HZ=10, enable=1 after reset -> small_sec_out=1 exactly 10 cycles after RUN is entered; seconds_out=1 at 100 cycles.
REQ-041 Set 23:59:59, small_sec preset by run to 99, count-up, defaults -> on the next tick all fields=0 and day_wrap high for exactly 1 cycle.
REQ-042 Set 00:00:01, count_down=1, enable=1 -> after TICK_HZ ticks all fields=0, done pulses once, state_out=3, fields stay at 0.
REQ-043 Same-cycle inc and dec edges in SET -> no change; inc edges with setting_enable=0 -> no change.
REQ-044 Reset asserted between clock edges during RUN -> all outputs read 0 before the next clock edge.
